// File: rtl/decode_stage.sv
// RV64I decode stage: 32x64 register file, immediate/control decode, load-use detection, ID/EX register.
// Optional macro DECODE_REGFILE_BYPASS_EN forwards a same-cycle writeback into the operand reads.
module decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [63:0] pc_current_instruction,
  input  logic [63:0] pc_next_instruction,
  input  logic        stall,
  input  logic        flush,
  input  logic        write_enable,
  input  logic [4:0]  write_register,
  input  logic [63:0] write_data,
  output logic        hazard_stall,
  output logic        valid,
  output logic        illegal,
  output logic [63:0] read_data_1,
  output logic [63:0] read_data_2,
  output logic [63:0] immediate,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7_bit,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic        branch_op,
  output logic        jump,
  output logic        word_op,
  output logic [63:0] pc_current_out,
  output logic [63:0] pc_next_out
);

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [63:0] read_data_1;
    logic [63:0] read_data_2;
    logic [63:0] immediate;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_bit;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        branch_op;
    logic        jump;
    logic        word_op;
    logic [63:0] pc_current;
    logic [63:0] pc_next;
  } idex_t;

  logic [63:0] regs [32];
  logic [63:0] rf_rd1, rf_rd2;
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        uses_rs1, uses_rs2;
  idex_t       dec, idex_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (write_enable && write_register != 5'd0) begin
      regs[write_register] <= write_data;
    end
  end

  always_comb begin
    rf_rd1 = (instruction[19:15] == 5'd0) ? 64'd0 : regs[instruction[19:15]];
    rf_rd2 = (instruction[24:20] == 5'd0) ? 64'd0 : regs[instruction[24:20]];
`ifdef DECODE_REGFILE_BYPASS_EN
    if (write_enable && write_register != 5'd0 && write_register == instruction[19:15])
      rf_rd1 = write_data;
    if (write_enable && write_register != 5'd0 && write_register == instruction[24:20])
      rf_rd2 = write_data;
`endif
  end

  assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{51{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {{32{instruction[31]}}, instruction[31:12], 12'b0};
  assign imm_j = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // Register fields are forwarded raw; uses_rs1/uses_rs2 say whether they matter for hazards.
  always_comb begin
    dec             = '0;
    uses_rs1        = 1'b0;
    uses_rs2        = 1'b0;
    dec.valid       = 1'b1;
    dec.read_data_1 = rf_rd1;
    dec.read_data_2 = rf_rd2;
    dec.rs1         = instruction[19:15];
    dec.rs2         = instruction[24:20];
    dec.rd          = instruction[11:7];
    dec.opcode      = instruction[6:0];
    dec.funct3      = instruction[14:12];
    dec.funct7_bit  = instruction[30];
    dec.pc_current  = pc_current_instruction;
    dec.pc_next     = pc_next_instruction;
    case (instruction[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.immediate = imm_u;
      end
      OPC_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.immediate = imm_j;
      end
      OPC_JALR: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.jump      = 1'b1;
        dec.immediate = imm_i;
        uses_rs1      = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch_op = 1'b1;
        dec.immediate = imm_b;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPC_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.immediate  = imm_i;
        uses_rs1       = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.immediate = imm_s;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.word_op   = (instruction[6:0] == OPC_OP_IMM_32);
        dec.immediate = imm_i;
        uses_rs1      = 1'b1;
      end
      OPC_OP, OPC_OP_32: begin
        dec.reg_write = 1'b1;
        dec.word_op   = (instruction[6:0] == OPC_OP_32);
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign hazard_stall = !reset && idex_q.valid && idex_q.mem_read && (idex_q.rd != 5'd0) &&
                        ((uses_rs1 && dec.rs1 == idex_q.rd) || (uses_rs2 && dec.rs2 == idex_q.rd));

  // Flush beats stall so a redirect always kills the slot; stall beats the load-use bubble.
  always_ff @(posedge clock) begin
    if (reset)             idex_q <= '0;
    else if (flush)        idex_q <= '0;
    else if (stall)        idex_q <= idex_q;
    else if (hazard_stall) idex_q <= '0;
    else                   idex_q <= dec;
  end

  assign valid          = idex_q.valid;
  assign illegal        = idex_q.illegal;
  assign read_data_1    = idex_q.read_data_1;
  assign read_data_2    = idex_q.read_data_2;
  assign immediate      = idex_q.immediate;
  assign rs1            = idex_q.rs1;
  assign rs2            = idex_q.rs2;
  assign rd             = idex_q.rd;
  assign opcode         = idex_q.opcode;
  assign funct3         = idex_q.funct3;
  assign funct7_bit     = idex_q.funct7_bit;
  assign reg_write      = idex_q.reg_write;
  assign mem_read       = idex_q.mem_read;
  assign mem_write      = idex_q.mem_write;
  assign mem_to_reg     = idex_q.mem_to_reg;
  assign alu_src        = idex_q.alu_src;
  assign branch_op      = idex_q.branch_op;
  assign jump           = idex_q.jump;
  assign word_op        = idex_q.word_op;
  assign pc_current_out = idex_q.pc_current;
  assign pc_next_out    = idex_q.pc_next;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected ID/EX contents are queued when an instruction is driven
// and checked after the following clock edge; hazard_stall is checked before each edge.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [63:0] pc_current_instruction, pc_next_instruction;
  logic        stall, flush, write_enable;
  logic [4:0]  write_register;
  logic [63:0] write_data;
  logic        hazard_stall, valid, illegal;
  logic [63:0] read_data_1, read_data_2, immediate;
  logic [4:0]  rs1, rs2, rd;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_bit;
  logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch_op, jump, word_op;
  logic [63:0] pc_current_out, pc_next_out;

  always #5 clock = ~clock;

  decode_stage dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .pc_current_instruction(pc_current_instruction), .pc_next_instruction(pc_next_instruction),
    .stall(stall), .flush(flush), .write_enable(write_enable),
    .write_register(write_register), .write_data(write_data),
    .hazard_stall(hazard_stall), .valid(valid), .illegal(illegal),
    .read_data_1(read_data_1), .read_data_2(read_data_2), .immediate(immediate),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .funct3(funct3), .funct7_bit(funct7_bit),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .branch_op(branch_op), .jump(jump), .word_op(word_op),
    .pc_current_out(pc_current_out), .pc_next_out(pc_next_out)
  );

  // ctrl packs {reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch_op, jump, word_op}
  typedef struct packed {
    logic        valid;
    logic        illegal;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        f7;
    logic [63:0] imm;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] pcc;
    logic [63:0] pcn;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input logic [7:0] ctrl, input logic [4:0] e_rd, e_rs1, e_rs2,
                              input logic [6:0] op, input logic [2:0] f3, input logic f7,
                              input logic [63:0] imm, d1, d2, pc, input logic ill);
    exp_t e;
    e.valid = 1'b1; e.illegal = ill; e.ctrl = ctrl;
    e.rd = e_rd; e.rs1 = e_rs1; e.rs2 = e_rs2;
    e.opcode = op; e.funct3 = f3; e.f7 = f7;
    e.imm = imm; e.rd1 = d1; e.rd2 = d2;
    e.pcc = pc; e.pcn = pc + 64'd1;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] instr, input logic [63:0] pc,
                               input logic st, input logic fl, input logic we,
                               input logic [4:0] wr, input logic [63:0] wd,
                               input logic rst, input exp_t e);
    instruction            = instr;
    pc_current_instruction = pc;
    pc_next_instruction    = pc + 64'd1;
    stall                  = st;
    flush                  = fl;
    write_enable           = we;
    write_register         = wr;
    write_data             = wd;
    reset                  = rst;
    sb.push_back(e);
    last_exp = e;
  endtask

  task automatic checkHazard(input string tag, input logic expv);
    #1;
    cmp({tag, "/hazard_stall"}, {63'd0, hazard_stall}, {63'd0, expv});
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    cmp({tag, "/valid"},   {63'd0, valid},   {63'd0, e.valid});
    cmp({tag, "/illegal"}, {63'd0, illegal}, {63'd0, e.illegal});
    cmp({tag, "/ctrl"},    {56'd0, reg_write, mem_read, mem_write, mem_to_reg,
                            alu_src, branch_op, jump, word_op}, {56'd0, e.ctrl});
    cmp({tag, "/rd"},      {59'd0, rd},  {59'd0, e.rd});
    cmp({tag, "/rs1"},     {59'd0, rs1}, {59'd0, e.rs1});
    cmp({tag, "/rs2"},     {59'd0, rs2}, {59'd0, e.rs2});
    cmp({tag, "/opcode"},  {57'd0, opcode}, {57'd0, e.opcode});
    cmp({tag, "/funct3"},  {61'd0, funct3}, {61'd0, e.funct3});
    cmp({tag, "/funct7"},  {63'd0, funct7_bit}, {63'd0, e.f7});
    cmp({tag, "/imm"},     immediate, e.imm);
    cmp({tag, "/rd1"},     read_data_1, e.rd1);
    cmp({tag, "/rd2"},     read_data_2, e.rd2);
    cmp({tag, "/pc_cur"},  pc_current_out, e.pcc);
    cmp({tag, "/pc_next"}, pc_next_out, e.pcn);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addi5, nop, beq, jalr, lui, bad, add655, add600, sd, ld7, ld0, add870, add800;
    logic [63:0] byp;
    exp_t e_ld7, e_add870;
    addi5  = 32'h00500093;
    nop    = 32'h00000013;
    beq    = 32'hFE000EE3;
    jalr   = 32'hFFF00067;
    lui    = 32'h800000B7;
    bad    = 32'h0000007F;
    add655 = 32'h00528333;
    add600 = 32'h00000333;
    sd     = 32'hFE50BC23;
    ld7    = 32'h0000B383;
    ld0    = 32'h0000B003;
    add870 = 32'h00038433;
    add800 = 32'h00000433;
`ifdef DECODE_REGFILE_BYPASS_EN
    byp = 64'hABCD;
`else
    byp = 64'h1234;
`endif

    // Reset and first decode
    applyStimulus(addi5, 64'h100, 0, 0, 0, 5'd0, 64'd0, 1, '0);
    checkHazard("reset", 1'b0);
    checkOutput("reset");
    applyStimulus(addi5, 64'h101, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h88, 5'd1, 5'd0, 5'd5, 7'h13, 3'd0, 1'b0, 64'd5, 64'd0, 64'd0, 64'h101, 1'b0));
    checkHazard("addi", 1'b0);
    checkOutput("addi");

    // Immediate formats and illegal opcode
    applyStimulus(beq, 64'h102, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h04, 5'd29, 5'd0, 5'd0, 7'h63, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'd0, 64'h102, 1'b0));
    checkHazard("beq", 1'b0);
    checkOutput("beq");
    applyStimulus(jalr, 64'h103, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h8A, 5'd0, 5'd0, 5'd31, 7'h67, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'h103, 1'b0));
    checkHazard("jalr", 1'b0);
    checkOutput("jalr");
    applyStimulus(lui, 64'h104, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h88, 5'd1, 5'd0, 5'd0, 7'h37, 3'd0, 1'b0, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'd0, 64'h104, 1'b0));
    checkHazard("lui", 1'b0);
    checkOutput("lui");
    applyStimulus(bad, 64'h105, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h00, 5'd0, 5'd0, 5'd0, 7'h7F, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'h105, 1'b1));
    checkHazard("illegal", 1'b0);
    checkOutput("illegal");

    // Writeback then read, x0 write ignored
    applyStimulus(nop, 64'h106, 0, 0, 1, 5'd5, 64'h1234, 0,
                  mk(8'h88, 5'd0, 5'd0, 5'd0, 7'h13, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'h106, 1'b0));
    checkHazard("wb_x5", 1'b0);
    checkOutput("wb_x5");
    applyStimulus(add655, 64'h107, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h80, 5'd6, 5'd5, 5'd5, 7'h33, 3'd0, 1'b0, 64'd0, 64'h1234, 64'h1234, 64'h107, 1'b0));
    checkHazard("read_x5", 1'b0);
    checkOutput("read_x5");
    applyStimulus(nop, 64'h108, 0, 0, 1, 5'd0, 64'd7, 0,
                  mk(8'h88, 5'd0, 5'd0, 5'd0, 7'h13, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'h108, 1'b0));
    checkHazard("wb_x0", 1'b0);
    checkOutput("wb_x0");
    applyStimulus(add600, 64'h109, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h80, 5'd6, 5'd0, 5'd0, 7'h33, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'h109, 1'b0));
    checkHazard("read_x0", 1'b0);
    checkOutput("read_x0");

    // Same-cycle write/read of x5
    applyStimulus(add655, 64'h10A, 0, 0, 1, 5'd5, 64'hABCD, 0,
                  mk(8'h80, 5'd6, 5'd5, 5'd5, 7'h33, 3'd0, 1'b0, 64'd0, byp, byp, 64'h10A, 1'b0));
    checkHazard("bypass", 1'b0);
    checkOutput("bypass");
    applyStimulus(add655, 64'h10B, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h80, 5'd6, 5'd5, 5'd5, 7'h33, 3'd0, 1'b0, 64'd0, 64'hABCD, 64'hABCD, 64'h10B, 1'b0));
    checkHazard("after_bypass", 1'b0);
    checkOutput("after_bypass");
    applyStimulus(sd, 64'h10C, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h28, 5'd24, 5'd1, 5'd5, 7'h23, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'hABCD, 64'h10C, 1'b0));
    checkHazard("sd", 1'b0);
    checkOutput("sd");

    // Load-use hazard inserts one bubble
    applyStimulus(ld7, 64'h10D, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'hD8, 5'd7, 5'd1, 5'd0, 7'h03, 3'd3, 1'b0, 64'd0, 64'd0, 64'd0, 64'h10D, 1'b0));
    checkHazard("ld7", 1'b0);
    checkOutput("ld7");
    applyStimulus(add870, 64'h10E, 0, 0, 0, 5'd0, 64'd0, 0, '0);
    checkHazard("loaduse", 1'b1);
    checkOutput("loaduse");
    applyStimulus(add870, 64'h10E, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h80, 5'd8, 5'd7, 5'd0, 7'h33, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'h10E, 1'b0));
    checkHazard("loaduse_issue", 1'b0);
    checkOutput("loaduse_issue");
    applyStimulus(ld0, 64'h10F, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'hD8, 5'd0, 5'd1, 5'd0, 7'h03, 3'd3, 1'b0, 64'd0, 64'd0, 64'd0, 64'h10F, 1'b0));
    checkHazard("ld_x0", 1'b0);
    checkOutput("ld_x0");
    applyStimulus(add800, 64'h110, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h80, 5'd8, 5'd0, 5'd0, 7'h33, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'h110, 1'b0));
    checkHazard("read_after_ld_x0", 1'b0);
    checkOutput("read_after_ld_x0");

    // Flush together with a load-use hazard
    e_ld7 = mk(8'hD8, 5'd7, 5'd1, 5'd0, 7'h03, 3'd3, 1'b0, 64'd0, 64'd0, 64'd0, 64'h111, 1'b0);
    applyStimulus(ld7, 64'h111, 0, 0, 0, 5'd0, 64'd0, 0, e_ld7);
    checkHazard("ld7_b", 1'b0);
    checkOutput("ld7_b");
    applyStimulus(add870, 64'h112, 0, 1, 0, 5'd0, 64'd0, 0, '0);
    checkHazard("flush_hazard", 1'b1);
    checkOutput("flush_hazard");

    // Stall together with a load-use hazard holds the load
    e_ld7 = mk(8'hD8, 5'd7, 5'd1, 5'd0, 7'h03, 3'd3, 1'b0, 64'd0, 64'd0, 64'd0, 64'h113, 1'b0);
    applyStimulus(ld7, 64'h113, 0, 0, 0, 5'd0, 64'd0, 0, e_ld7);
    checkHazard("ld7_c", 1'b0);
    checkOutput("ld7_c");
    applyStimulus(add870, 64'h114, 1, 0, 0, 5'd0, 64'd0, 0, last_exp);
    checkHazard("stall_hazard", 1'b1);
    checkOutput("stall_hazard");
    applyStimulus(add870, 64'h114, 0, 0, 0, 5'd0, 64'd0, 0, '0);
    checkHazard("stall_hazard_bubble", 1'b1);
    checkOutput("stall_hazard_bubble");
    e_add870 = mk(8'h80, 5'd8, 5'd7, 5'd0, 7'h33, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'h114, 1'b0);
    applyStimulus(add870, 64'h114, 0, 0, 0, 5'd0, 64'd0, 0, e_add870);
    checkHazard("stall_hazard_issue", 1'b0);
    checkOutput("stall_hazard_issue");

    // Plain stall for three cycles, then reset during stall
    for (int i = 0; i < 3; i++) begin
      applyStimulus(addi5, 64'h200 + 64'(i), 1, 0, 0, 5'd0, 64'd0, 0, last_exp);
      checkHazard("stall_hold", 1'b0);
      checkOutput("stall_hold");
    end
    applyStimulus(addi5, 64'h203, 1, 0, 1, 5'd5, 64'h55, 1, '0);
    checkHazard("reset_in_stall", 1'b0);
    checkOutput("reset_in_stall");
    applyStimulus(add655, 64'h204, 0, 0, 0, 5'd0, 64'd0, 0,
                  mk(8'h80, 5'd6, 5'd5, 5'd5, 7'h33, 3'd0, 1'b0, 64'd0, 64'd0, 64'd0, 64'h204, 1'b0));
    checkHazard("regfile_cleared", 1'b0);
    checkOutput("regfile_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

RV64I decode stage between `fetch` and execute. Holds the 32×64 integer register file and decodes the fetched instruction into operands, a sign-extended immediate and control signals. It also detects load-use hazards. All results land in a single registered pipeline boundary (ID/EX) with stall and flush control.

## Interface
Parameters: none.

Clock and reset: one clock; reset is synchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears the register file and ID/EX

Inputs from fetch:
- instruction  in  32  instruction from fetch
- pc_current_instruction  in  64  PC of `instruction`, word index
- pc_next_instruction  in  64  PC + 1, word index

Pipeline control:
- stall  in  1  downstream hold; ID/EX keeps its contents
- flush  in  1  taken branch/jump; ID/EX loads a bubble

Writeback:
- write_enable  in  1  writeback strobe
- write_register  in  5  writeback destination
- write_data  in  64  writeback value

Outputs:
- hazard_stall  out  1  combinational; fetch must hold its PC and instruction this cycle
- valid  out  1  ID/EX holds a real instruction
- illegal  out  1  unsupported opcode
- read_data_1, read_data_2  out  64 each  rs1/rs2 values
- immediate  out  64  sign-extended immediate, standard RISC-V byte offset
- rs1, rs2, rd  out  5 each  register fields
- opcode  out  7; funct3  out  3; funct7_bit  out  1 (instruction[30])
- reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch_op, jump, word_op  out  1 each  control
- pc_current_out, pc_next_out  out  64 each  forwarded PCs

## Operation
Register file:
- x0 reads 0; writes to x0 are ignored.
- Writes commit at posedge when write_enable=1.

Supported opcodes:
- LUI 0110111 (U), AUIPC 0010111 (U), JAL 1101111 (J), JALR 1100111 (I)
- BRANCH 1100011 (B), LOAD 0000011 (I), STORE 0100011 (S)
- OP-IMM 0010011 (I), OP 0110011 (none), OP-IMM-32 0011011 (I), OP-32 0111011 (none)

Immediates:
- Built per the RISC-V base formats, then sign-extended from instruction[31].
- U-type: {sext(instr[31:12]), 12'b0}.
- Formats with no immediate produce 0.

Control decode:
- reg_write: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, OP-IMM-32, OP-32.
- alu_src: LUI, AUIPC, JALR, LOAD, STORE, OP-IMM, OP-IMM-32.
- mem_read and mem_to_reg: LOAD.
- mem_write: STORE.
- branch_op: BRANCH.
- jump: JAL, JALR.
- word_op: OP-IMM-32, OP-32.
- Any other opcode: illegal=1, valid=1, all controls 0.

Register usage:
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32.
- rs2 is used by BRANCH, STORE, OP, OP-32.

Load-use hazard:
- hazard_stall=1 when all of the following hold: ID/EX has valid=1, ID/EX has mem_read=1, ID/EX rd≠0, and the incoming instruction uses rs1 or rs2 equal to that rd.

ID/EX update priority at posedge:
1. reset: all outputs 0.
2. flush: bubble.
3. stall: hold all outputs.
4. hazard_stall: bubble.
5. Otherwise: load the decoded instruction with valid=1.

A bubble means valid=0, illegal=0, all controls 0, and all other fields 0.

## Timing
- Latency is 1 cycle: an instruction present before edge N appears on the outputs after edge N.
- hazard_stall is purely combinational from `instruction` and ID/EX. It is never asserted while reset=1.
- flush and hazard_stall in the same cycle: the bubble is loaded and hazard_stall is still reported. Fetch is redirected by branch, which takes precedence over the hold.
- stall takes precedence over hazard_stall for ID/EX. hazard_stall stays asserted, so fetch also holds.
- Reset mid-stream: the register file clears at the same edge; writeback that cycle is discarded.
- Write and read of the same nonzero register in the same cycle: see Configuration.

## Configuration
- `DECODE_REGFILE_BYPASS_EN` defined: a same-cycle write to rs1/rs2 (write_enable=1, write_register==rs, rs≠0) is bypassed. read_data_1/2 capture write_data.
- Undefined: read_data captures the pre-write register value. Writeback must then be separated from the reader by at least one cycle.

## Test plan
- Reset: assert reset 1 cycle with instruction=0x00500093 → all outputs 0, valid=0. Next edge: valid=1, rd=1, immediate=5, alu_src=1, reg_write=1.
- Immediates: decode 0xFE000EE3 (BEQ x0,x0,-4) → immediate=0xFFFF_FFFF_FFFF_FFFC, branch_op=1. Decode 0xFFF00067 (JALR x0,-1(x0)) → immediate=all ones, jump=1.
- Writeback/read: write x5=0x1234 via writeback. Next cycle decode ADD x6,x5,x5 (0x00528333) → read_data_1=read_data_2=0x1234. Write x0=7 → x0 still reads 0.
- Bypass: write x5=0xABCD in the same cycle as decoding 0x00528333 → read_data=0xABCD with the macro, old value without it.
- Load-use: LD x7,0(x1) then ADD x8,x7,x0 → hazard_stall=1 for 1 cycle and a bubble is inserted. ADD then issues with valid=1. LD to x0 followed by a reader of x0 → no stall.
- Flush/stall: flush with a valid instruction → bubble. stall=1 for 3 cycles → outputs unchanged. reset=1 during stall → outputs 0.
